// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and instruction memory (slave).
// The request holds address and strobe until the memory answers with imemReady.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemReady;
  logic [31:0]     imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemRdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over the imem bus, presents one instruction at a time to decode.
// Optional macro FETCH_TIMEOUT_EN adds a per-fetch wait limit (MAX_WAIT) that substitutes a NOP and sets fetchErr.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int              MAX_WAIT = 15
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  fetch_unit_if.master    imem,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic            instrValid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic            fetchErr
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            capture;
  logic            timeout;
  logic            consume;
  logic [XLEN-1:0] pc_nxt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (capture || timeout) state_nxt = HOLD;
      HOLD:    if (!stall) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: request only while fetching, valid only while holding
  // ---------------------------------------------------------------------------
  always_comb begin
    imem.imemReq = 1'b0;
    instrValid   = 1'b0;
    case (state)
      FETCH:   imem.imemReq = 1'b1;
      HOLD:    instrValid   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign capture = (state == FETCH) && imem.imemReady;
  assign consume = instrValid && !stall;

  // Misaligned targets are silently aligned; pc+4 wraps modulo 2^XLEN.
  assign pcPlus4 = pc + XLEN'(4);
  assign pc_nxt  = pcSrc ? (pcTarget & ~XLEN'(3)) : pcPlus4;

  assign imem.imemAddr = pc;
  assign op            = instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      if (capture) begin
        instr <= imem.imemRdata;
      end else if (timeout) begin
        instr <= NOP;
      end
      if (consume) begin
        pc <= pc_nxt;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Fetch timeout: count unanswered FETCH cycles, give up on the MAX_WAIT-th one
  // ---------------------------------------------------------------------------
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout = (state == FETCH) && !imem.imemReady
                   && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // The counter sits at zero outside FETCH, so every fetch starts its budget fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      fetchErr <= 1'b0;
    end else begin
      if (state != FETCH) begin
        wait_cnt <= '0;
      end else if (!imem.imemReady) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        fetchErr <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus contract checks
  // ---------------------------------------------------------------------------
  a_req_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (imem.imemReq && !imem.imemReady && !timeout)
        |=> (imem.imemReq && $stable(imem.imemAddr))
  );

  a_one_phase: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(imem.imemReq && instrValid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then random wait states, stalls and redirects
// checked by a scoreboard against a PC-sequence model of the fetch stage.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          N_RAND   = 3000;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            pcSrc;
  logic [XLEN-1:0] pcTarget;
  logic [31:0]     instr;
  logic [6:0]      op;
  logic            instrValid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcPlus4;
`ifdef FETCH_TIMEOUT_EN
  logic            fetchErr;
`endif

  fetch_unit_if #(.XLEN(XLEN)) imem ();

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
`ifdef FETCH_TIMEOUT_EN
    ,
    .MAX_WAIT(15)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pcSrc     (pcSrc),
    .pcTarget  (pcTarget),
    .imem      (imem),
    .instr     (instr),
    .op        (op),
    .instrValid(instrValid),
    .pc        (pc),
    .pcPlus4   (pcPlus4)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetchErr  (fetchErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          n_consumed = 0;
  bit          mon_en     = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: exp_q[0] is the PC decode should currently be shown.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en && rst_n && instrValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: instruction at pc %h with no expected entry", pc);
      end else begin
        logic [31:0] e_pc;
        logic [31:0] e_word;
        e_pc   = exp_q[0];
        e_word = mem_fn(e_pc);
        check("sb_pc", pc, e_pc);
        check("sb_instr", instr, e_word);
        check("sb_op", {25'd0, op}, {25'd0, e_word[6:0]});
        check("sb_pcplus4", pcPlus4, e_pc + 32'd4);
        check("sb_req_in_hold", {31'd0, imem.imemReq}, 32'd0);
        if (!stall) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] m_pc;
    int          waits;

    rst_n    = 1'b0;
    stall    = 1'b0;
    pcSrc    = 1'b0;
    pcTarget = '0;
    imem.imemReady = 1'b1;
    imem.imemRdata = 32'h0050_0093;
    #12;

    // Reset values
    check("rst_req", {31'd0, imem.imemReq}, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_op", {25'd0, op}, 32'h13);
    check("rst_pc", pc, RESET_PC);
`ifdef FETCH_TIMEOUT_EN
    check("rst_fetcherr", {31'd0, fetchErr}, 32'd0);
`endif

    // Zero-wait memory: first valid two cycles after release
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_req", {31'd0, imem.imemReq}, 32'd1);
    check("first_addr", imem.imemAddr, 32'h0);
    check("first_valid_early", {31'd0, instrValid}, 32'd0);
    step();
    check("first_valid", {31'd0, instrValid}, 32'd1);
    check("first_instr", instr, 32'h0050_0093);
    check("first_op", {25'd0, op}, 32'h13);
    check("first_pc", pc, 32'h0);
    check("first_pcplus4", pcPlus4, 32'h4);
    check("hold_req", {31'd0, imem.imemReq}, 32'd0);
    step();
    check("second_req", {31'd0, imem.imemReq}, 32'd1);
    check("second_addr", imem.imemAddr, 32'h4);
    step();

    // Three wait states: request and address steady for four cycles
    imem.imemReady = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("wait_req", {31'd0, imem.imemReq}, 32'd1);
      check("wait_addr", imem.imemAddr, 32'h8);
      check("wait_valid", {31'd0, instrValid}, 32'd0);
      imem.imemRdata = $urandom;
      if (i == 3) begin
        imem.imemReady = 1'b1;
        imem.imemRdata = 32'h00C0_006F;
      end
      step();
    end
    check("wait_done_valid", {31'd0, instrValid}, 32'd1);
    check("wait_done_instr", instr, 32'h00C0_006F);
    check("wait_done_op", {25'd0, op}, 32'h6F);
    check("wait_done_pc", pc, 32'h8);

    // Stall in HOLD with pcSrc toggling and bus noise: everything frozen
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pcSrc          = ~pcSrc;
      pcTarget       = $urandom;
      imem.imemReady = 1'($urandom_range(0, 1));
      imem.imemRdata = $urandom;
      step();
      check("stall_valid", {31'd0, instrValid}, 32'd1);
      check("stall_pc", pc, 32'h8);
      check("stall_instr", instr, 32'h00C0_006F);
      check("stall_req", {31'd0, imem.imemReq}, 32'd0);
    end
    stall          = 1'b0;
    pcSrc          = 1'b1;
    pcTarget       = 32'h0000_0102;
    imem.imemReady = 1'b1;
    imem.imemRdata = 32'h0010_0113;
    step();
    check("redirect_addr", imem.imemAddr, 32'h0000_0100);
    check("redirect_req", {31'd0, imem.imemReq}, 32'd1);
    pcSrc = 1'b0;
    step();
    check("redirect_pc", pc, 32'h0000_0100);

    // Wrap-around at the top of the address space (target also misaligned)
    pcSrc    = 1'b1;
    pcTarget = 32'hFFFF_FFFF;
    step();
    check("wrap_addr_top", imem.imemAddr, 32'hFFFF_FFFC);
    pcSrc = 1'b0;
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pcplus4", pcPlus4, 32'h0);
    imem.imemRdata = 32'h1234_5678;
    step();
    check("wrap_addr_zero", imem.imemAddr, 32'h0);
    step();
    imem.imemReady = 1'b0;
    step();
    check("midfetch_addr", imem.imemAddr, 32'h4);

    // Asynchronous reset in the middle of a fetch
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, imem.imemReq}, 32'd0);
    check("async_rst_pc", pc, RESET_PC);
    check("async_rst_valid", {31'd0, instrValid}, 32'd0);
    check("async_rst_instr", instr, NOP);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: NOP substituted after 15 wait cycles, error sticky
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("to_err_before", {31'd0, fetchErr}, 32'd0);
    for (int i = 1; i < 15; i++) begin
      step();
      check("to_still_waiting", {31'd0, instrValid}, 32'd0);
    end
    step();
    check("to_valid", {31'd0, instrValid}, 32'd1);
    check("to_instr", instr, NOP);
    check("to_err", {31'd0, fetchErr}, 32'd1);
    imem.imemReady = 1'b1;
    imem.imemRdata = 32'h00A0_0513;
    step();
    step();
    check("to_next_instr", instr, 32'h00A0_0513);
    check("to_next_pc", pc, RESET_PC + 32'd4);
    check("to_err_sticky", {31'd0, fetchErr}, 32'd1);
    rst_n = 1'b0;
    #1;
`endif

    // Random phase: model tracks the PC sequence decode should see
    stall          = 1'b0;
    pcSrc          = 1'b0;
    imem.imemReady = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = RESET_PC;
    exp_q.delete();
    exp_q.push_back(m_pc);
    waits  = $urandom_range(0, 3);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      step();
      stall    = ($urandom_range(0, 9) < 3);
      pcSrc    = ($urandom_range(0, 3) == 0);
      pcTarget = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                              : 32'($urandom);
      if (instrValid && !stall) begin
        m_pc = pcSrc ? (pcTarget & ~32'h3) : (m_pc + 32'd4);
        exp_q.push_back(m_pc);
      end
      if (imem.imemReq) begin
        if (waits == 0) begin
          imem.imemReady = 1'b1;
          imem.imemRdata = mem_fn(imem.imemAddr);
          waits          = $urandom_range(0, 3);
        end else begin
          imem.imemReady = 1'b0;
          imem.imemRdata = $urandom;
          waits--;
        end
      end else begin
        imem.imemReady = 1'($urandom_range(0, 1));
        imem.imemRdata = $urandom;
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
    check("rand_progress", {31'd0, n_consumed >= 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and requests instructions from instruction memory over a ready-based handshake with variable wait states.
- Presents the fetched word, its opcode field and PC to decode, and holds them until decode consumes them.
- Computes the next PC from the decoder's pcSrc and the execute-stage target.

Parameters:
- XLEN, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- MAX_WAIT, 15, wait-cycle limit per fetch; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode/execute not ready to consume the instruction.
- pcSrc  in  1  take pcTarget instead of pc+4; from the main decoder (jump || zero&&branch).
- pcTarget  in  XLEN  branch/jump target from execute.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  XLEN  fetch address (= pc).
- imemReady  in  1  memory returns data this cycle.
- imemRdata  in  32  instruction word from memory.
- instr  out  32  fetched instruction register.
- op  out  7  instr[6:0], wired to the decoder op input.
- instrValid  out  1  instr/op/pc valid for decode.
- pc  out  XLEN  PC of the instruction in instr.
- pcPlus4  out  XLEN  pc + 4, used for the jal link value.
- fetchErr  out  1  fetch timeout flag; present only with FETCH_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion takes effect immediately, including mid-fetch.
- Reset values: pc=RESET_PC, state=IDLE, imemReq=0, instrValid=0, instr=32'h00000013 (NOP), fetchErr=0, wait counter=0.
- State IDLE: entered only from reset; moves to FETCH on the first clock edge after rst_n deasserts. imemReq=0.
- State FETCH: imemReq=1 and imemAddr=pc, both stable while in FETCH.
  - If imemReady=1 at a clock edge: instr<=imemRdata, instrValid<=1, go to HOLD.
  - If imemReady=0: stay in FETCH.
  - Minimum latency is 1 cycle from request to instrValid=1; with zero-wait memory, reset-release to first instrValid takes 2 cycles.
- State HOLD: imemReq=0; instr, pc and instrValid=1 are held.
  - Consume event: instrValid && !stall at a clock edge. On it: pc <= pcSrc ? {pcTarget[XLEN-1:2],2'b00} : pc+4; instrValid<=0; go to FETCH.
  - While stall=1, all outputs are frozen. pcSrc and pcTarget are ignored except at the consume edge.
- Throughput: one instruction per 2 cycles with zero-wait memory. No speculative prefetch.
- Arithmetic: pc+4 wraps modulo 2^XLEN (e.g. 32'hFFFFFFFC -> 32'h00000000); pcPlus4 wraps the same way.
- Alignment: pcTarget[1:0] is forced to 0; misaligned targets are silently aligned.
- Simultaneous events:
  - stall is irrelevant outside HOLD.
  - imemReady is ignored outside FETCH.
  - pcSrc=1 with stall=1: no redirect until stall drops, then the value of pcSrc at that edge is used.
- op is always instr[6:0], including the reset NOP (7'b0010011).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter increments each FETCH cycle with imemReady=0 and clears on entry to FETCH.
  - When the counter reaches MAX_WAIT, fetchErr latches to 1 (sticky until reset), instr<=NOP, instrValid<=1, and the state goes to HOLD, so decode sees a NOP and pc advances normally.
- Undefined: no counter and no fetchErr port; FETCH waits indefinitely.

Test Plan:
- Reset, imemReady tied 1, imemRdata=32'h00500093: imemAddr=0 on the first FETCH cycle; instrValid=1, op=7'b0010011, pc=0, pcPlus4=4 two cycles after release; next fetch imemAddr=4.
- imemReady low for 3 cycles: imemReq=1 and imemAddr stable for 4 cycles, instrValid rises only after imemReady=1, instr equals the returned word.
- stall=1 for 5 cycles in HOLD with pcSrc toggling: outputs frozen; stall drops with pcSrc=1, pcTarget=32'h00000102: next imemAddr=32'h00000100.
- pc=32'hFFFFFFFC, consume with pcSrc=0: next imemAddr=0, pcPlus4 was 0.
- rst_n asserted mid-FETCH with imemReady=0: imemReq drops immediately (asynchronously), pc=RESET_PC, instrValid=0, instr=NOP.
- FETCH_TIMEOUT_EN, MAX_WAIT=15, imemReady held 0: fetchErr=1 and instrValid=1 with instr=32'h00000013 after 15 wait cycles; fetchErr stays 1 through later fetches.
